// File: rtl/mbus_arbiter_pkg.sv
// Shared mbus types: opcodes, responses, arbiter state and burst helpers.
package mbus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BURST4 = 2'd2,
      BURST8 = 2'd3
   } mbus_opcode_e;

   typedef enum logic [2:0] {
      NULL             = 3'd0,
      READ_VALID       = 3'd1,
      WRITE_VALID      = 3'd2,
      READ_ADDR_ERROR  = 3'd3,
      WRITE_ADDR_ERROR = 3'd4,
      ADDR_ERROR       = 3'd5
   } mbus_resp_e;

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } mbus_arb_state_e;

   localparam int unsigned MBUS_BEAT_BYTES = 4;

   function automatic logic [3:0] mbus_burst_len(mbus_opcode_e op);
      case (op)
         SINGLE:  return 4'd1;
         BURST4:  return 4'd4;
         BURST8:  return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic mbus_resp_is_err(mbus_resp_e resp);
      return resp inside {READ_ADDR_ERROR, WRITE_ADDR_ERROR, ADDR_ERROR};
   endfunction

endpackage

// File: rtl/mbus_rr_picker.sv
// Combinational round-robin picker: first eligible index above rr_ptr, wrapping at N.
module mbus_rr_picker #(
   parameter  int unsigned N    = 4,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    eligible,
   input  logic [IdxW-1:0] rr_ptr,
   output logic [N-1:0]    winner,
   output logic [IdxW-1:0] win_idx,
   output logic            win_valid
);

   always_comb begin
      int unsigned j;
      j         = 0;
      winner    = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      // Offset 1..N so the last winner has the lowest priority.
      for (int unsigned k = 1; k <= N; k++) begin
         j = (32'(rr_ptr) + k) % N;
         if (!win_valid && eligible[j]) begin
            win_valid  = 1'b1;
            win_idx    = IdxW'(j);
            winner[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mbus_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one mbus slave between NUM_MASTERS masters.
// Owns slave address/opcode for a whole transfer and force-completes hung beats.
module mbus_arbiter
   import mbus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic                          MCLK,
   input  logic                          MRESETn,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS*32-1:0]     m_addr,
   input  logic [NUM_MASTERS*32-1:0]     m_wdata,
   input  logic [NUM_MASTERS-1:0]        m_read,
   input  mbus_opcode_e [NUM_MASTERS-1:0] m_opcode,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic [NUM_MASTERS-1:0]        m_rdy,
   output mbus_resp_e                    m_resp,
   output logic [31:0]                   m_rdata,
   output logic                          s_req,
   output logic [31:0]                   s_addr,
   output logic [31:0]                   s_wdata,
   output logic                          s_read,
   output mbus_opcode_e                  s_opcode,
   input  logic                          s_rdy,
   input  mbus_resp_e                    s_resp,
   input  logic [31:0]                   s_rdata,
   output logic [15:0]                   err_cnt
);

   localparam int unsigned IdxW = $clog2(NUM_MASTERS);
   localparam int unsigned TmoW = $clog2(TIMEOUT);

   mbus_arb_state_e        state;
   logic [IdxW-1:0]        rr;
   logic [3:0]             beats_left;
   logic [TmoW-1:0]        tmo;

   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] winner;
   logic [IdxW-1:0]        win_idx;
   logic                   win_valid;
   logic [31:0]            win_addr;
   mbus_opcode_e           win_op;
   logic                   win_read;
   logic [31:0]            cur_wdata;
   logic                   tmo_hit;
   logic                   beat_done;
   logic                   beat_err;

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         eligible[i] = m_req[i] && (m_opcode[i] != IDLE);
      end
   end

   mbus_rr_picker #(
      .N (NUM_MASTERS)
   ) u_picker (
      .eligible  (eligible),
      .rr_ptr    (rr),
      .winner    (winner),
      .win_idx   (win_idx),
      .win_valid (win_valid)
   );

   // rr doubles as the granted index while in XFER.
   always_comb begin
      win_addr  = '0;
      win_op    = IDLE;
      win_read  = 1'b0;
      cur_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (IdxW'(i) == win_idx) begin
            win_addr = m_addr[i*32 +: 32];
            win_op   = m_opcode[i];
            win_read = m_read[i];
         end
         if (IdxW'(i) == rr) begin
            cur_wdata = m_wdata[i*32 +: 32];
         end
      end
   end

   assign s_wdata   = (state == XFER) ? cur_wdata : '0;
   assign tmo_hit   = (tmo == TmoW'(TIMEOUT - 1));
   assign beat_done = (state == XFER) && (s_rdy || tmo_hit);
   // A real slave response always beats the timeout.
   assign beat_err  = s_rdy ? mbus_resp_is_err(s_resp) : 1'b1;

   always_ff @(posedge MCLK or negedge MRESETn) begin
      if (!MRESETn) begin
         state      <= ARB;
         rr         <= IdxW'(NUM_MASTERS - 1);
         beats_left <= '0;
         tmo        <= '0;
         m_gnt      <= '0;
         m_rdy      <= '0;
         m_resp     <= NULL;
         m_rdata    <= '0;
         s_req      <= 1'b0;
         s_addr     <= '0;
         s_read     <= 1'b0;
         s_opcode   <= IDLE;
         err_cnt    <= '0;
      end else begin
         m_rdy   <= '0;
         m_resp  <= NULL;
         m_rdata <= '0;
         unique case (state)
            ARB: begin
               if (win_valid) begin
                  state      <= XFER;
                  rr         <= win_idx;
                  m_gnt      <= winner;
                  s_req      <= 1'b1;
                  s_addr     <= win_addr;
                  s_read     <= win_read;
                  s_opcode   <= win_op;
                  beats_left <= mbus_burst_len(win_op);
                  tmo        <= '0;
               end
            end
            XFER: begin
               if (beat_done) begin
                  m_rdy      <= m_gnt;
                  m_resp     <= s_rdy ? s_resp : ADDR_ERROR;
                  m_rdata    <= s_rdy ? s_rdata : '0;
                  s_addr     <= s_addr + 32'(MBUS_BEAT_BYTES);
                  beats_left <= beats_left - 4'd1;
                  tmo        <= '0;
                  if (beat_err && (err_cnt != 16'hFFFF)) begin
                     err_cnt <= err_cnt + 16'd1;
                  end
                  if (beats_left == 4'd1) begin
                     state    <= ARB;
                     m_gnt    <= '0;
                     s_req    <= 1'b0;
                     s_read   <= 1'b0;
                     s_opcode <= IDLE;
                  end
               end else begin
                  tmo <= tmo + TmoW'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: doc/mbus_arbiter.md
Name: mbus_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one mbus slave between NUM_MASTERS requesters.
- Latches the winning master's request, owns the slave-side address and opcode for the whole SINGLE/BURST4/BURST8 transfer, and counts beats.
- Routes per-beat data and responses back to the granted master.
- Enforces a per-beat response timeout; a hung beat completes with ADDR_ERROR.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT, 64, cycles without s_rdy before a beat is force-completed (>=2).

Ports:
- MCLK  in  1  clock; all state changes on rising edge.
- MRESETn  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master request; a master holds it until granted.
- m_addr  in  NUM_MASTERS*32  per-master start address (MADDR).
- m_wdata  in  NUM_MASTERS*32  per-master write data, sampled per beat while granted (MWDATA).
- m_read  in  NUM_MASTERS  per-master MREAD.
- m_opcode  in  NUM_MASTERS x mbus_opcode_e  per-master MOPCODE.
- m_gnt  out  NUM_MASTERS  one-hot grant, high for the whole transfer.
- m_rdy  out  NUM_MASTERS  one-hot beat-complete strobe to the granted master.
- m_resp  out  mbus_resp_e  response for the completing beat (broadcast).
- m_rdata  out  32  read data for the completing beat (broadcast).
- s_req  out  1  beat request to the slave.
- s_addr  out  32  beat address.
- s_wdata  out  32  beat write data.
- s_read  out  1  latched MREAD.
- s_opcode  out  mbus_opcode_e  latched opcode.
- s_rdy  in  1  slave beat complete.
- s_resp  in  mbus_resp_e  slave response (MRESP).
- s_rdata  in  32  slave read data (MRDATA).
- err_cnt  out  16  saturating count of error and timeout beats.

Behaviour:
- Reset (async, MRESETn low) values:
  - m_gnt=0, m_rdy=0, m_resp=NULL, m_rdata=0.
  - s_req=0, s_addr=0, s_wdata=0, s_read=0, s_opcode=IDLE.
  - err_cnt=0; rr pointer=NUM_MASTERS-1; state=ARB.
- Reset mid-burst abandons the transfer immediately; no m_rdy is issued.
- States: ARB, XFER.
- ARB:
  - A master is eligible when m_req=1 and m_opcode!=IDLE. A request with opcode IDLE is never granted.
  - The winner is the first eligible index searching upward from rr+1, modulo NUM_MASTERS.
  - On a winner, at the next edge:
    - m_gnt[w]=1, state=XFER, rr=w.
    - Latch s_opcode, s_read, and base address (s_addr=m_addr[w]).
    - beats_left = 1, 4 or 8 for SINGLE, BURST4, BURST8.
    - Clear the timeout counter.
  - With no eligible master, remain in ARB with all outputs idle.
- XFER:
  - s_req=1; s_wdata follows m_wdata[w] combinationally.
  - A beat completes when s_rdy=1 or when the timeout counter reaches TIMEOUT-1.
- On a beat completing with s_rdy:
  - m_rdy[w] pulses for 1 cycle, registered, in the cycle after s_rdy.
  - m_resp=s_resp and m_rdata=s_rdata, registered.
- On a beat completing by timeout:
  - m_rdy[w] pulses with m_resp=ADDR_ERROR and m_rdata=0.
  - err_cnt increments.
- err_cnt also increments on s_resp of READ_ADDR_ERROR, WRITE_ADDR_ERROR or ADDR_ERROR.
- err_cnt saturates at 16'hFFFF.
- At each completed beat: s_addr += 4 (wraps modulo 2^32), beats_left decrements, timeout counter clears.
- Error responses do not abort a burst; all beats run.
- Final beat: m_gnt drops at the same edge as the final m_rdy, and the state returns to ARB.
  - Minimum gap between transfers is 1 cycle, i.e. one ARB cycle.
  - Back-to-back grants rotate fairly.
- Between beats, s_req stays high; the slave may assert s_rdy on consecutive cycles.
- If s_rdy and timeout coincide, s_rdy wins and no error is counted.
- Master-side inputs are ignored while in XFER, except m_wdata[w].
  - Dropping m_req mid-burst does not shorten the burst.
- s_rdy while in ARB is ignored.

Decomposition:
- Add to the shared mbus types package:
  - typedef mbus_arb_state_e {ARB, XFER}.
  - Function mbus_burst_len(mbus_opcode_e) returning 0/1/4/8.
  - Constant MBUS_BEAT_BYTES=4.
- Sub-module mbus_rr_picker: combinational round-robin priority picker. Inputs: eligible vector, rr pointer. Outputs: one-hot winner, index, valid. Reused by other mbus arbiters.

Test Plan:
- Single master, reset release: m_req[0]=1, SINGLE, addr 0x100, read; slave s_rdy 2 cycles after grant with READ_VALID, 0xDEADBEEF -> m_gnt[0] high 3 cycles; one m_rdy[0] with READ_VALID/0xDEADBEEF; err_cnt=0.
- BURST8 address walk: m_req[2] BURST8 at 0xFFFFFFF8, s_rdy tied 1 -> s_addr sequence F8, FC, 00, 04, 08, 0C, 10, 14 (wrap); exactly 8 m_rdy[2] pulses; gnt drops with the 8th.
- Fairness: all 4 masters request SINGLE continuously, s_rdy=1 -> grant order 0,1,2,3,0,1...; each grant 2 cycles apart.
- Timeout: BURST4 on master 1, slave never asserts s_rdy, TIMEOUT=64 -> 4 m_rdy pulses 64 cycles apart, each ADDR_ERROR; err_cnt=4.
- Error mid-burst: BURST4 with s_resp WRITE_ADDR_ERROR on beat 2 -> all 4 beats completed; err_cnt=1; opcode-IDLE request on master 3 is never granted.
- Reset mid-BURST8 after beat 3: MRESETn low 1 cycle -> all outputs at reset values asynchronously; next grant is to master 0 when masters 0 and 1 both request.
